// File: rtl/cpu_isa_pkg.sv
// MIPS-subset ISA constants shared by decode, control and the ALU.
// Also holds the decoded control bundle type.
package cpu_isa_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam int ALU_OP_W = 3;
    localparam logic [ALU_OP_W-1:0] ALU_OP_ADD = 3'b000;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SUB = 3'b001;
    localparam logic [ALU_OP_W-1:0] ALU_OP_AND = 3'b010;
    localparam logic [ALU_OP_W-1:0] ALU_OP_OR  = 3'b011;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SLT = 3'b100;
    localparam logic [ALU_OP_W-1:0] ALU_OP_BRC = 3'b110;

    typedef struct packed {
        logic                reg_write;
        logic [4:0]          wr_addr;
        logic [4:0]          rs_addr;
        logic [4:0]          rt_addr;
        logic                alu_src2;
        logic [ALU_OP_W-1:0] alu_op;
        logic                mem_read;
        logic                mem_write;
        logic                mem_to_reg;
        logic                branch;
        logic                branch_ne;
        logic                jump;
        logic                illegal;
    } ctrl_t;

endpackage

// File: rtl/id_decode_comb.sv
// Purely combinational instruction decoder: instruction word -> control bundle,
// extended immediate and the register-read flags used for hazard detection.
module id_decode_comb
    import cpu_isa_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output ctrl_t           ctrl,
    output logic [XLEN-1:0] imm,
    output logic            reads_rs,
    output logic            reads_rt
);

    logic [5:0] opcode;
    logic [5:0] funct;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];

    always_comb begin
        // NOTE: every output gets a default before the case so no path infers a latch.
        ctrl         = '0;
        ctrl.rs_addr = instr[25:21];
        ctrl.rt_addr = instr[20:16];
        ctrl.alu_op  = ALU_OP_ADD;
        ctrl.illegal = 1'b1;
        imm          = {{(XLEN-16){instr[15]}}, instr[15:0]};
        reads_rs     = 1'b1;
        reads_rt     = 1'b0;

        case (opcode)
            OP_RTYPE: begin
                reads_rt       = 1'b1;
                ctrl.illegal   = 1'b0;
                ctrl.reg_write = 1'b1;
                ctrl.wr_addr   = instr[15:11];
                case (funct)
                    FN_ADD:  ctrl.alu_op = ALU_OP_ADD;
                    FN_SUB:  ctrl.alu_op = ALU_OP_SUB;
                    FN_AND:  ctrl.alu_op = ALU_OP_AND;
                    FN_OR:   ctrl.alu_op = ALU_OP_OR;
                    FN_SLT:  ctrl.alu_op = ALU_OP_SLT;
                    default: begin
                        ctrl.illegal   = 1'b1;
                        ctrl.reg_write = 1'b0;
                        ctrl.wr_addr   = '0;
                    end
                endcase
            end
            OP_ADDI, OP_ANDI, OP_ORI, OP_LW: begin
                ctrl.illegal   = 1'b0;
                ctrl.reg_write = 1'b1;
                ctrl.wr_addr   = instr[20:16];
                ctrl.alu_src2  = 1'b1;
                if (opcode == OP_ANDI || opcode == OP_ORI) begin
                    ctrl.alu_op = (opcode == OP_ANDI) ? ALU_OP_AND : ALU_OP_OR;
                    imm         = {{(XLEN-16){1'b0}}, instr[15:0]};
                end
                if (opcode == OP_LW) begin
                    ctrl.mem_read   = 1'b1;
                    ctrl.mem_to_reg = 1'b1;
                end
            end
            OP_SW: begin
                reads_rt       = 1'b1;
                ctrl.illegal   = 1'b0;
                ctrl.alu_src2  = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                reads_rt       = 1'b1;
                ctrl.illegal   = 1'b0;
                ctrl.branch    = 1'b1;
                ctrl.branch_ne = (opcode == OP_BNE);
                ctrl.alu_op    = ALU_OP_BRC;
            end
            OP_J: begin
                reads_rs     = 1'b0;
                ctrl.illegal = 1'b0;
                ctrl.jump    = 1'b1;
                imm          = {{(XLEN-26){1'b0}}, instr[25:0]};
            end
            default: ;
        endcase

        // Register $0 is hardwired, so a write to it is dropped here once for all ops.
        if (ctrl.wr_addr == '0) ctrl.reg_write = 1'b0;
    end

endmodule

// File: rtl/id_stage_pipe.sv
// Registered decode stage: valid/ready on both sides, single output register,
// load-use bubble insertion, flush and a saturating bubble counter.
module id_stage_pipe
    import cpu_isa_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int ALUOP_W     = 3,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_instr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_reg_write,
    output logic [4:0]             out_wr_addr,
    output logic [4:0]             out_rs_addr,
    output logic [4:0]             out_rt_addr,
    output logic                   out_alu_src2,
    output logic [ALUOP_W-1:0]     out_alu_op,
    output logic                   out_mem_read,
    output logic                   out_mem_write,
    output logic                   out_mem_to_reg,
    output logic                   out_branch,
    output logic                   out_branch_ne,
    output logic                   out_jump,
    output logic [XLEN-1:0]        out_imm,
    output logic                   out_illegal,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    ctrl_t           dec;
    logic [XLEN-1:0] dec_imm;
    logic            reads_rs;
    logic            reads_rt;

    id_decode_comb #(.XLEN(XLEN)) u_decode (
        .instr    (in_instr),
        .ctrl     (dec),
        .imm      (dec_imm),
        .reads_rs (reads_rs),
        .reads_rt (reads_rt)
    );

    ctrl_t           out_q;
    logic [XLEN-1:0] imm_q;
    logic            ld_vld;
    logic [4:0]      ld_dst;
    logic            can_adv;
    logic            hazard;

    assign can_adv  = !out_valid || out_ready;
    assign hazard   = in_valid && ld_vld && (ld_dst != '0) &&
                      ((reads_rs && dec.rs_addr == ld_dst) || (reads_rt && dec.rt_addr == ld_dst));
    assign in_ready = rst_n && can_adv && !hazard && !flush;

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_q     <= '0;
            imm_q     <= '0;
            ld_vld    <= 1'b0;
            ld_dst    <= '0;
            stall_cnt <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_q     <= '0;
            imm_q     <= '0;
            ld_vld    <= 1'b0;
            ld_dst    <= '0;
        end else if (can_adv) begin
            if (in_valid && !hazard) begin
                out_valid <= 1'b1;
                out_q     <= dec;
                imm_q     <= dec_imm;
                ld_vld    <= dec.mem_read;
                ld_dst    <= dec.wr_addr;
            end else begin
                // Empty slot or load-use bubble: data fields hold, only the valid drops.
                out_valid <= 1'b0;
                ld_vld    <= 1'b0;
                if (hazard && !(&stall_cnt)) stall_cnt <= stall_cnt + STALL_CNT_W'(1);
            end
        end
    end

    assign out_reg_write  = out_q.reg_write;
    assign out_wr_addr    = out_q.wr_addr;
    assign out_rs_addr    = out_q.rs_addr;
    assign out_rt_addr    = out_q.rt_addr;
    assign out_alu_src2   = out_q.alu_src2;
    assign out_alu_op     = ALUOP_W'(out_q.alu_op);
    assign out_mem_read   = out_q.mem_read;
    assign out_mem_write  = out_q.mem_write;
    assign out_mem_to_reg = out_q.mem_to_reg;
    assign out_branch     = out_q.branch;
    assign out_branch_ne  = out_q.branch_ne;
    assign out_jump       = out_q.jump;
    assign out_illegal    = out_q.illegal;
    assign out_imm        = imm_q;

endmodule
